sega_pad_scanner: RTL
=====================

// Module: sega_pad_scanner
// PURPOSE
//   Parametrised multi-pad reader for Sega-style 3/6-button gamepads on GPIO.
//   Once per video frame, drives the shared pad_select line through the 8-phase
//   6-button protocol and samples every pad. Publishes active-high button
//   vectors, new-press pulses and pad-type flags to the world/graphics logic.
//   Replaces the single-pad controller in the top level.
// PARAMETERS
//   NUM_PADS       2    number of pads sharing pad_select (1..4)
//   SETTLE_CYCLES  500  clk cycles per select half-phase (10 us @ 50 MHz), >=4
//   TRIG_RISE      0    0: scan starts on frame_sync falling edge; 1: rising edge
// PORTS
//   clk         in   1            50 MHz system clock
//   reset       in   1            async, active-low; all state to reset values
//   frame_sync  in   1            frame trigger (VGA vsync); async, 2-FF synced
//   pad_data    in   NUM_PADS*6   per pad {start_c,a_b,right,left_x,down_y,up_z}, active-low, 2-FF synced
//   pad_select  out  1            shared select to all pads
//   buttons     out  NUM_PADS*12  per pad {mode,z,y,x,start,c,b,a,right,left,down,up}, 1=held
//   pressed     out  NUM_PADS*12  1-cycle pulse on 0->1 of a buttons bit, same cycle as valid
//   six_button  out  NUM_PADS     1 = pad identified as 6-button this frame
//   connected   out  NUM_PADS     1 = pad present this frame
//   valid       out  1            1-cycle strobe: outputs updated this cycle
// BEHAVIOUR
//   Reset: pad_select=1, buttons=0, pressed=0, six_button=0, connected=0, valid=0, FSM=IDLE.
//   FSM: IDLE -> SCAN (phase 0..7, SETTLE_CYCLES each) -> PUBLISH -> IDLE.
//   IDLE: select=1; leave on configured edge of synced frame_sync.
//   SCAN: select = 1 in even phases, 0 in odd; raw data sampled on the last cycle of each phase.
//     ph0 (sel=1): up,down,left,right,b,c.  ph1 (sel=0): a,start; left&right both low => connected.
//     ph5 (sel=0): up,down,left,right all low => six_button.
//     ph6 (sel=1): z,y,x,mode on up_z,down_y,left_x,right. Other phases: samples discarded.
//   PUBLISH: one cycle; decode registered; valid=1 on the following cycle with new outputs.
//   Latency: t0 = clk edge where sync stage 1 captures the active edge; valid high exactly
//     8*SETTLE_CYCLES+4 cycles after t0. Holds until next valid.
//   Triggers arriving during SCAN/PUBLISH are ignored, not queued.
//   Disconnected pad: its buttons, pressed, six_button forced 0.
//   3-button pad (connected, not six): x,y,z,mode bits forced 0.
//   pressed = new_buttons & ~old_buttons per bit, old = previous published value.
//   Reset asserted mid-scan: immediate return to reset values; next scan needs a fresh edge.
// CONFIGURATION
//   SEGA_PAD_DEBOUNCE_EN defined: a buttons bit changes only when two consecutive scans
//     agree (extra 12-bit history register per pad); connected/six_button are not debounced.
//     Press latency becomes two frames.
//   Not defined: buttons take each scan's decode directly.
// STRUCTURE
//   sega_pad_pkg: button bit indices (BTN_UP=0 .. BTN_MODE=11), phase localparams
//     PH_BASE=0, PH_AST=1, PH_ID=5, PH_EXT=6, state encoding IDLE/SCAN/PUBLISH.
//   Sub-module sega_pad_decode (one instance per pad via generate): holds per-pad
//     sample registers, debounce history, pressed edge detect.
//   Top: synchronisers, shared FSM/phase/timer, select generation.
// TESTING
//   1 pad, SETTLE=4; pad model 6-button, A+Start held; falling frame_sync ->
//     valid at t0+36; buttons=0x090; six=1; connected=1; pressed=0x090.
//   Same stimulus again, no change -> buttons=0x090, pressed=0x000.
//   3-button model holding C; ph5 lines high -> six=0, buttons=0x040, bits 11:8=0.
//   Pad 1 all lines pulled high (absent), NUM_PADS=2 -> connected=2'b01; pad 1 buttons=0.
//   Second frame_sync edge mid-SCAN -> no restart; exactly one valid; select pattern
//     1,0,1,0,1,0,1,0 then 1.
//   Reset low during phase 3 -> select=1, all outputs 0 immediately; next edge gives full scan.
//   DEBOUNCE_EN: Z pressed one frame only -> buttons Z stays 0; two frames -> Z=1 on second valid.

Source files
------------

// File: rtl/sega_pad_pkg.sv
// rtl/sega_pad_pkg.sv - shared button indices, pad line indices, scan phases and FSM encoding
package sega_pad_pkg;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_B     = 5;
   localparam int BTN_C     = 6;
   localparam int BTN_START = 7;
   localparam int BTN_X     = 8;
   localparam int BTN_Y     = 9;
   localparam int BTN_Z     = 10;
   localparam int BTN_MODE  = 11;

   // Physical pad lines, as wired into each 6-bit pad_data slice.
   localparam int LINE_UP_Z    = 0;
   localparam int LINE_DOWN_Y  = 1;
   localparam int LINE_LEFT_X  = 2;
   localparam int LINE_RIGHT   = 3;
   localparam int LINE_A_B     = 4;
   localparam int LINE_START_C = 5;

   localparam logic [2:0] PH_BASE = 3'd0;
   localparam logic [2:0] PH_AST  = 3'd1;
   localparam logic [2:0] PH_ID   = 3'd5;
   localparam logic [2:0] PH_EXT  = 3'd6;
   localparam logic [2:0] PH_LAST = 3'd7;

   localparam logic [11:0] EXT_MASK = 12'hF00;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      PUBLISH = 2'd2
   } scan_state_t;

   // Absent pads report nothing; 3-button pads cannot report x/y/z/mode.
   function automatic logic [11:0] mask_buttons(input logic [11:0] raw,
                                                input logic        conn,
                                                input logic        six);
      if (!conn)
         return 12'h000;
      else if (!six)
         return raw & ~EXT_MASK;
      else
         return raw;
   endfunction

endpackage

// File: rtl/sega_pad_decode.sv
// rtl/sega_pad_decode.sv - per-pad sampling, decode and press detection
// Optional SEGA_PAD_DEBOUNCE_EN: a button bit only changes when two consecutive scans agree.
module sega_pad_decode
   import sega_pad_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  pad_data,
   input  logic        sample_en,
   input  logic [2:0]  phase,
   input  logic        latch_en,
   input  logic        publish_en,
   output logic [11:0] buttons,
   output logic [11:0] pressed,
   output logic        six_button,
   output logic        connected
);

   logic [11:0] raw;
   logic        raw_conn;
   logic        raw_six;
   logic [11:0] dec;
   logic        dec_conn;
   logic        dec_six;
   logic [11:0] next_buttons;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         raw      <= '0;
         raw_conn <= 1'b0;
         raw_six  <= 1'b0;
      end else if (sample_en) begin
         case (phase)
            PH_BASE: begin
               raw[BTN_UP]    <= ~pad_data[LINE_UP_Z];
               raw[BTN_DOWN]  <= ~pad_data[LINE_DOWN_Y];
               raw[BTN_LEFT]  <= ~pad_data[LINE_LEFT_X];
               raw[BTN_RIGHT] <= ~pad_data[LINE_RIGHT];
               raw[BTN_B]     <= ~pad_data[LINE_A_B];
               raw[BTN_C]     <= ~pad_data[LINE_START_C];
            end
            PH_AST: begin
               raw[BTN_A]     <= ~pad_data[LINE_A_B];
               raw[BTN_START] <= ~pad_data[LINE_START_C];
               // A real pad grounds left/right while select is low.
               raw_conn       <= ~pad_data[LINE_LEFT_X] & ~pad_data[LINE_RIGHT];
            end
            PH_ID: begin
               raw_six <= ~(pad_data[LINE_UP_Z] | pad_data[LINE_DOWN_Y] |
                            pad_data[LINE_LEFT_X] | pad_data[LINE_RIGHT]);
            end
            PH_EXT: begin
               raw[BTN_Z]    <= ~pad_data[LINE_UP_Z];
               raw[BTN_Y]    <= ~pad_data[LINE_DOWN_Y];
               raw[BTN_X]    <= ~pad_data[LINE_LEFT_X];
               raw[BTN_MODE] <= ~pad_data[LINE_RIGHT];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dec      <= '0;
         dec_conn <= 1'b0;
         dec_six  <= 1'b0;
      end else if (latch_en) begin
         dec      <= mask_buttons(raw, raw_conn, raw_six);
         dec_conn <= raw_conn;
         dec_six  <= raw_conn & raw_six;
      end
   end

`ifdef SEGA_PAD_DEBOUNCE_EN
   logic [11:0] history;
   logic [11:0] agree;

   assign agree        = ~(dec ^ history);
   assign next_buttons = dec_conn ? ((agree & dec) | (~agree & buttons)) : 12'h000;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         history <= '0;
      else if (publish_en)
         history <= dec;
   end
`else
   assign next_buttons = dec;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buttons    <= '0;
         pressed    <= '0;
         six_button <= 1'b0;
         connected  <= 1'b0;
      end else if (publish_en) begin
         buttons    <= next_buttons;
         pressed    <= next_buttons & ~buttons;
         six_button <= dec_six;
         connected  <= dec_conn;
      end else begin
         pressed <= '0;
      end
   end

endmodule

// File: rtl/sega_pad_scanner.sv
// rtl/sega_pad_scanner.sv - frame-triggered multi-pad Sega 3/6-button scanner
// Optional SEGA_PAD_DEBOUNCE_EN is handled inside each sega_pad_decode instance.
module sega_pad_scanner
   import sega_pad_pkg::*;
#(
   parameter int NUM_PADS      = 2,
   parameter int SETTLE_CYCLES = 500,
   parameter int TRIG_RISE     = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_sync,
   input  logic [NUM_PADS*6-1:0]  pad_data,
   output logic                   pad_select,
   output logic [NUM_PADS*12-1:0] buttons,
   output logic [NUM_PADS*12-1:0] pressed,
   output logic [NUM_PADS-1:0]    six_button,
   output logic [NUM_PADS-1:0]    connected,
   output logic                   valid
);

   localparam int         TW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(SETTLE_CYCLES - 1);
   // Syncs reset to the level after the active edge so reset release never fakes a trigger.
   localparam logic       SYNC_INIT  = (TRIG_RISE != 0);

   logic                  fs_meta;
   logic                  fs_sync;
   logic                  fs_prev;
   logic [NUM_PADS*6-1:0] data_meta;
   logic [NUM_PADS*6-1:0] data_sync;
   logic                  trig;

   scan_state_t           state;
   logic [2:0]            phase;
   logic [TW-1:0]         timer;
   logic                  publish_q;
   logic                  sample_en;
   logic                  latch_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fs_meta   <= SYNC_INIT;
         fs_sync   <= SYNC_INIT;
         fs_prev   <= SYNC_INIT;
         data_meta <= '1;
         data_sync <= '1;
      end else begin
         fs_meta   <= frame_sync;
         fs_sync   <= fs_meta;
         fs_prev   <= fs_sync;
         data_meta <= pad_data;
         data_sync <= data_meta;
      end
   end

   assign trig      = (TRIG_RISE != 0) ? (fs_sync & ~fs_prev) : (~fs_sync & fs_prev);
   assign sample_en = (state == SCAN) && (timer == TIMER_LAST);
   assign latch_en  = (state == PUBLISH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         phase      <= PH_BASE;
         timer      <= '0;
         pad_select <= 1'b1;
         publish_q  <= 1'b0;
         valid      <= 1'b0;
      end else begin
         publish_q <= (state == PUBLISH);
         valid     <= publish_q;
         case (state)
            IDLE: begin
               pad_select <= 1'b1;
               if (trig) begin
                  state <= SCAN;
                  phase <= PH_BASE;
                  timer <= '0;
               end
            end
            SCAN: begin
               if (timer == TIMER_LAST) begin
                  timer <= '0;
                  if (phase == PH_LAST) begin
                     state      <= PUBLISH;
                     pad_select <= 1'b1;
                  end else begin
                     phase      <= phase + 3'd1;
                     // Next phase is odd (select low) exactly when the current one is even.
                     pad_select <= phase[0];
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            PUBLISH: begin
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               pad_select <= 1'b1;
            end
         endcase
      end
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      sega_pad_decode u_decode (
         .clk        (clk),
         .reset      (reset),
         .pad_data   (data_sync[p*6 +: 6]),
         .sample_en  (sample_en),
         .phase      (phase),
         .latch_en   (latch_en),
         .publish_en (publish_q),
         .buttons    (buttons[p*12 +: 12]),
         .pressed    (pressed[p*12 +: 12]),
         .six_button (six_button[p]),
         .connected  (connected[p])
      );
   end

endmodule
